// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC waveform sequencer.
//   - default datapath widths
//   - state encoding (also exported on o2_state)
//   - midscale code driven to the DAC whenever no waveform is playing
package dac_seq_pkg;

  localparam int DAC_DATA_W   = 14;
  localparam int DAC_ADDR_W   = 7;
  localparam int DAC_SETTLE_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ARMED  = 2'd2,
    ST_PLAY   = 2'd3
  } state_t;

  // Two's complement zero is midscale for the DAC.
  localparam int MIDSCALE = 0;

endpackage

// File: rtl/dac_sample_ram.sv
// Sample RAM: simple dual-port, one write port and one synchronous read port.
//   clk      : clock
//   rst      : async active-low reset (read register only, contents untouched)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : load read register from mem[rd_addr]
//   rd_clr   : load read register with CLR_VAL (ignored when rd_en)
//   rd_addr  : read address
//   rd_data  : registered read data, doubles as the DAC output register
// Same-address write/read in one cycle returns the old contents.
module dac_sample_ram #(
  parameter int              DATA_W  = 14,
  parameter int              ADDR_W  = 7,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Both processes see pre-edge mem, which gives read-first ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rd_data <= CLR_VAL;
    else if (rd_en)  rd_data <= mem[rd_addr];
    else if (rd_clr) rd_data <= CLR_VAL;
  end

endmodule

// File: rtl/dac_waveform_sequencer.sv
// DAC waveform sequencer: loadable sample RAM, relay settle delay, triggered
// prescaled playback for a programmed loop count.
//   clk / rst          : clock, async active-low reset
//   i_wr_en, i7_wr_addr, is14_wr_data : sample RAM write port (always live)
//   i_start / i_stop   : start request / abort (levels, sampled)
//   i_trig             : playback trigger, sampled in ARMED
//   i7_last_index, i32_prescaler, i16_loops, i24_settle : config, latched on start
//   os14_data          : registered sample to DAC channel
//   o_data_valid       : pulse when os14_data takes a new sample
//   or_relay           : DAC output relay enable
//   o_busy, o_done, o2_state : status
module dac_waveform_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DATA_W   = DAC_DATA_W,
  parameter int ADDR_W   = DAC_ADDR_W,
  parameter int SETTLE_W = DAC_SETTLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i7_wr_addr,
  input  logic [DATA_W-1:0]   is14_wr_data,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_trig,
  input  logic [ADDR_W-1:0]   i7_last_index,
  input  logic [31:0]         i32_prescaler,
  input  logic [15:0]         i16_loops,
  input  logic [SETTLE_W-1:0] i24_settle,
  output logic [DATA_W-1:0]   os14_data,
  output logic                o_data_valid,
  output logic                or_relay,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o2_state
);

  localparam int SW1 = SETTLE_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]   last_index;
    logic [31:0]         prescaler;
    logic [15:0]         loops;
    logic [SETTLE_W-1:0] settle;
  } cfg_t;

  state_t              state_q, state_d;
  cfg_t                cfg_q, cfg_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [31:0]         presc_q, presc_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [15:0]         loop_q, loop_d;
  logic                tick, finish;
  logic [0:0]          vld_pipe;
  logic                done_q, relay_q;
  logic [SW1-1:0]      settle_nxt;
  logic                settle_done;

  // settle=0 still spends one cycle in SETTLE: (cnt+1) >= settle is true at once.
  assign settle_nxt  = {1'b0, settle_cnt_q} + SW1'(1);
  assign settle_done = settle_nxt >= {1'b0, cfg_q.settle};

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    settle_cnt_d = settle_cnt_q;
    presc_d      = presc_q;
    idx_d        = idx_q;
    loop_d       = loop_q;
    tick         = 1'b0;
    finish       = 1'b0;
    if (state_q != ST_IDLE && i_stop) begin
      // Abort outranks any tick in this cycle, so no read gets issued.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            cfg_d        = '{last_index: i7_last_index, prescaler: i32_prescaler,
                             loops: i16_loops, settle: i24_settle};
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_done) state_d = ST_ARMED;
          else             settle_cnt_d = settle_nxt[SETTLE_W-1:0];
        end
        ST_ARMED: begin
          if (i_trig) begin
            state_d = ST_PLAY;
            idx_d   = '0;
            presc_d = '0;
            loop_d  = '0;
          end
        end
        ST_PLAY: begin
          if (presc_q == cfg_q.prescaler) begin
            tick    = 1'b1;
            presc_d = '0;
            if (idx_q == cfg_q.last_index) begin
              idx_d  = '0;
              loop_d = loop_q + 16'd1;
              if (cfg_q.loops != 16'd0 && loop_d == cfg_q.loops) begin
                finish  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      settle_cnt_q <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      loop_q       <= '0;
      vld_pipe     <= '0;
      done_q       <= 1'b0;
      relay_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      settle_cnt_q <= settle_cnt_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      loop_q       <= loop_d;
      vld_pipe     <= tick;
      done_q       <= finish;
      // Relay stays on through the final-sample cycle and drops after it.
      relay_q      <= (state_d != ST_IDLE) || finish;
    end
  end

  // The RAM read register is the output register: loaded on a tick, held
  // between ticks while playing, forced to midscale otherwise.
  dac_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CLR_VAL(DATA_W'(MIDSCALE))
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (i_wr_en),
    .wr_addr(i7_wr_addr),
    .wr_data(is14_wr_data),
    .rd_en  (tick),
    .rd_clr (state_d != ST_PLAY),
    .rd_addr(idx_q),
    .rd_data(os14_data)
  );

  assign o_data_valid = vld_pipe[0];
  assign o_done       = done_q;
  assign or_relay     = relay_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o2_state     = state_q;

endmodule

// File: tb/tb_dac_waveform_sequencer.sv
module tb_dac_waveform_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [6:0]  i7_wr_addr = '0;
  logic [13:0] is14_wr_data = '0;
  logic        i_start = 1'b0, i_stop = 1'b0, i_trig = 1'b0;
  logic [6:0]  i7_last_index = '0;
  logic [31:0] i32_prescaler = '0;
  logic [15:0] i16_loops = '0;
  logic [23:0] i24_settle = '0;
  logic [13:0] os14_data;
  logic        o_data_valid, or_relay, o_busy, o_done;
  logic [1:0]  o2_state;

  always #5 clk = ~clk;

  dac_waveform_sequencer dut (
    .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i7_wr_addr(i7_wr_addr),
    .is14_wr_data(is14_wr_data), .i_start(i_start), .i_stop(i_stop), .i_trig(i_trig),
    .i7_last_index(i7_last_index), .i32_prescaler(i32_prescaler), .i16_loops(i16_loops),
    .i24_settle(i24_settle), .os14_data(os14_data), .o_data_valid(o_data_valid),
    .or_relay(or_relay), .o_busy(o_busy), .o_done(o_done), .o2_state(o2_state)
  );

  typedef struct { logic [13:0] d; bit last; } exp_t;
  exp_t        exp_q[$];
  logic [13:0] shadow [128];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 0, inf_mode = 0, have_prev = 0;
  logic [13:0] inf_val = '0;
  int gap_exp = 1, prev_cyc = 0, first_cyc = 0, n_valid = 0, trig_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Scoreboard: every valid pulse must match the next expected sample, its
  // done flag, and sit prescaler+1 cycles after the previous pulse.
  initial forever begin
    @(negedge clk);
    if (chk_en && rst) begin
      if (o_data_valid) begin
        n_valid++;
        if (!have_prev) first_cyc = cyc;
        else check("sample_gap", 32'(cyc - prev_cyc), 32'(gap_exp));
        have_prev = 1;
        prev_cyc  = cyc;
        if (inf_mode) begin
          check("sample_inf", 32'(os14_data), 32'(inf_val));
          check("done_inf", 32'(o_done), 0);
        end else if (exp_q.size() == 0) begin
          check("extra_sample", 32'(o_data_valid), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sample", 32'(os14_data), 32'(e.d));
          check("done_flag", 32'(o_done), 32'(e.last));
        end
      end else begin
        check("done_without_valid", 32'(o_done), 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    i_wr_en = 1'b1; i7_wr_addr = 7'(a); is14_wr_data = 14'(d); shadow[a] = 14'(d);
    step(1);
    i_wr_en = 1'b0;
  endtask

  task automatic start(input int last, input int presc, input int loops, input int settle);
    i7_last_index = 7'(last); i32_prescaler = 32'(presc);
    i16_loops = 16'(loops); i24_settle = 24'(settle);
    gap_exp = presc + 1;
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  // Counts cycles spent in SETTLE with the relay on, then checks ARMED.
  task automatic settle_phase(input string name, input int exp_n);
    int n = 0;
    for (int k = 0; k < 64 && o2_state == 2'd1; k++) begin
      n += int'(or_relay);
      step(1);
    end
    check({name, "_settle_cycles"}, 32'(n), 32'(exp_n));
    check({name, "_armed"}, 32'(o2_state), 2);
    check({name, "_armed_relay"}, 32'(or_relay), 1);
    check({name, "_armed_data"}, 32'(os14_data), 0);
  endtask

  task automatic trigger();
    have_prev = 0; n_valid = 0;
    trig_cyc = cyc;
    i_trig = 1'b1;
    step(1);
    i_trig = 1'b0;
  endtask

  task automatic build_exp(input int last, input int loops);
    for (int l = 0; l < loops; l++)
      for (int i = 0; i <= last; i++) begin
        exp_t e;
        e.d = shadow[i];
        e.last = (l == loops - 1) && (i == last);
        exp_q.push_back(e);
      end
  endtask

  // Waits for all expected samples, then checks the cycle after done.
  task automatic drain(input string name);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) step(1);
    check({name, "_drained"}, 32'(exp_q.size()), 0);
    check({name, "_post_data"}, 32'(os14_data), 0);
    check({name, "_post_relay"}, 32'(or_relay), 0);
    check({name, "_post_state"}, 32'(o2_state), 0);
    check({name, "_post_busy"}, 32'(o_busy), 0);
  endtask

  initial begin
    step(2);
    check("rst_data", 32'(os14_data), 0);
    check("rst_valid", 32'(o_data_valid), 0);
    check("rst_relay", 32'(or_relay), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_state", 32'(o2_state), 0);
    rst = 1'b1;
    step(1);
    wr(0, 100); wr(1, 200); wr(2, 300); wr(3, 400);

    // Four samples, two loops, back to back.
    chk_en = 1;
    build_exp(3, 2);
    start(3, 0, 2, 5);
    check("t1_state_settle", 32'(o2_state), 1);
    check("t1_relay_settle", 32'(or_relay), 1);
    settle_phase("t1", 5);
    trigger();
    drain("t1");
    check("t1_first_latency", 32'(first_cyc - trig_cyc), 2);
    check("t1_valid_count", 32'(n_valid), 8);

    // Prescaled: samples 4 cycles apart, exactly two pulses.
    build_exp(1, 1);
    start(1, 3, 1, 2);
    settle_phase("t2", 2);
    trigger();
    drain("t2");
    check("t2_first_latency", 32'(first_cyc - trig_cyc), 5);
    check("t2_valid_count", 32'(n_valid), 2);

    // Single-sample infinite playback, then abort.
    wr(0, 14'h2000);
    inf_mode = 1; inf_val = 14'h2000;
    start(0, 0, 0, 3);
    settle_phase("t3", 3);
    trigger();
    step(12);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    check("t3_stop_state", 32'(o2_state), 0);
    check("t3_stop_data", 32'(os14_data), 0);
    check("t3_stop_valid", 32'(o_data_valid), 0);
    check("t3_stop_done", 32'(o_done), 0);
    check("t3_stop_relay", 32'(or_relay), 0);
    check("t3_valid_count", 32'(n_valid), 12);
    step(1);
    inf_mode = 0;

    // Zero settle, trigger already high.
    build_exp(0, 1);
    have_prev = 0; n_valid = 0;
    i_trig = 1'b1;
    start(0, 0, 1, 0);
    check("t4_state_settle", 32'(o2_state), 1);
    settle_phase("t4", 1);
    step(1);
    check("t4_state_play", 32'(o2_state), 3);
    i_trig = 1'b0;
    drain("t4");
    check("t4_valid_count", 32'(n_valid), 1);

    // Write collision with the playback read, plus ignored start.
    wr(0, 100);
    build_exp(3, 2);
    exp_q[6].d = 14'd777;
    start(3, 0, 2, 1);
    settle_phase("t5", 1);
    trigger();
    step(2);
    i_wr_en = 1'b1; i7_wr_addr = 7'd2; is14_wr_data = 14'd777; shadow[2] = 14'd777;
    i_start = 1'b1; i16_loops = 16'd9;
    step(1);
    i_wr_en = 1'b0; i_start = 1'b0;
    check("t5_still_play", 32'(o2_state), 3);
    drain("t5");
    check("t5_valid_count", 32'(n_valid), 8);

    // Async reset in the middle of playback.
    chk_en = 0;
    start(3, 0, 0, 1);
    step(1);
    trigger();
    step(5);
    check("t6_pre_state", 32'(o2_state), 3);
    #2 rst = 1'b0;
    #1;
    check("t6_arst_data", 32'(os14_data), 0);
    check("t6_arst_relay", 32'(or_relay), 0);
    check("t6_arst_busy", 32'(o_busy), 0);
    check("t6_arst_valid", 32'(o_data_valid), 0);
    step(2);
    rst = 1'b1;
    step(1);
    check("t6_idle_after_rst", 32'(o2_state), 0);
    chk_en = 1;
    build_exp(3, 1);
    start(3, 1, 1, 3);
    settle_phase("t6", 3);
    trigger();
    drain("t6");
    check("t6_valid_count", 32'(n_valid), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
